ads131a0x_nios_cpu_debug_ocimem_seq: RTL and testbench

//  Sysclk-domain sequencer between the CPU debug-slave command decode (jdo + take_action_* strobes) and
//  the OCI debug RAM/register space. Turns JTAG debug commands into Avalon-MM master transfers on the
//  OCI port. Returns read data in MonDReg and status in monitor_ready/monitor_error to the debug slave.

---
 rtl/ads131a0x_nios_cpu_debug_ocimem_seq_pkg.sv | 26 ++
 rtl/ads131a0x_nios_cpu_debug_ocimem_tmo.sv | 47 ++++
 rtl/ads131a0x_nios_cpu_debug_ocimem_seq.sv | 202 ++++++++++++++++++++
 tb/tb_ads131a0x_nios_cpu_debug_ocimem_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ads131a0x_nios_cpu_debug_ocimem_seq_pkg.sv
// ---------------------------------------------------------------------------
// ads131a0x_nios_cpu_debug_ocimem_seq_pkg
// Shared definitions for the OCI memory debug sequencer: FSM state encoding
// and bit positions of the fields carried in the 38-bit jdo command payload.
// ---------------------------------------------------------------------------
package ads131a0x_nios_cpu_debug_ocimem_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } ocimem_state_e;

    localparam int JDO_W       = 38;
    localparam int RD_BIT      = 35;  // ocimem_a: follow the address load with a read
    localparam int CLR_ERR_BIT = 36;  // ocimem_a: clear the sticky error flag
    localparam int WDATA_MSB   = 34;
    localparam int WDATA_LSB   = 3;
    localparam int ADDR_LSB    = 2;

    // Width needed to hold a stall count of 0..tmo.
    function automatic int tmo_cnt_w(input int tmo);
        return (tmo < 1) ? 1 : $clog2(tmo + 1);
    endfunction

endpackage

// File: rtl/ads131a0x_nios_cpu_debug_ocimem_tmo.sv
// ---------------------------------------------------------------------------
// ads131a0x_nios_cpu_debug_ocimem_tmo
// Stall timeout counter for an in-flight OCI transfer.
// Ports:
//   clk       in  system clock
//   reset_n   in  asynchronous active-low reset
//   clr_i     in  restart the count (a new transfer is being launched)
//   inc_i     in  one waitrequest stall cycle elapsed
//   expired_o out this stall cycle is the TIMEOUT_CYC-th consecutive one
// ---------------------------------------------------------------------------
module ads131a0x_nios_cpu_debug_ocimem_tmo
    import ads131a0x_nios_cpu_debug_ocimem_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int CW = tmo_cnt_w(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q, cnt_d;

    // Asserted while the counter shows TIMEOUT_CYC-1 earlier stalls, so the
    // stall being counted now is the one that reaches the limit and the
    // request is dropped on this same edge.
    assign expired_o = inc_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ads131a0x_nios_cpu_debug_ocimem_seq.sv
// ---------------------------------------------------------------------------
// ads131a0x_nios_cpu_debug_ocimem_seq
// Turns decoded JTAG debug commands (jdo + take_action strobes) into single
// Avalon-MM transfers on the OCI port and reports data/status back to the
// debug slave.
// Ports:
//   clk, reset_n               system clock, async active-low reset
//   jdo[37:0]                  command payload
//   take_action_ocimem_a       load MonAReg from jdo, optional read / error clear
//   take_no_action_ocimem_a    MonAReg+1 then read
//   take_action_ocimem_b       write jdo[34:3] at MonAReg then MonAReg+1
//   oci_address/read/write/writedata, oci_readdata, oci_waitrequest
//                              Avalon-MM master
//   MonAReg, MonDReg           monitor address / data registers
//   monitor_ready              idle, previous command complete
//   monitor_error              sticky error (dropped command or timeout)
// ---------------------------------------------------------------------------
module ads131a0x_nios_cpu_debug_ocimem_seq
    import ads131a0x_nios_cpu_debug_ocimem_seq_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [ADDR_W-1:0] oci_address,
    output logic              oci_read,
    output logic              oci_write,
    output logic [31:0]       oci_writedata,
    input  logic [31:0]       oci_readdata,
    input  logic              oci_waitrequest,
    output logic [ADDR_W-1:0] MonAReg,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    ocimem_state_e     state_q, state_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [31:0]       mdata_q, mdata_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              rdy_q, rdy_d;
    logic              err_q, err_d;

    logic              tmo_clr;
    logic              tmo_inc;
    logic              tmo_exp;
    logic              multi_strobe;
    logic              any_strobe;
    logic [31:0]       jdo_wdata;
    logic [ADDR_W-1:0] jdo_addr;

    // jdo bits that no command field uses.
    logic unused_jdo;
    assign unused_jdo = ^{jdo[JDO_W-1], jdo[ADDR_LSB-1:0]};

    assign jdo_wdata = jdo[WDATA_MSB:WDATA_LSB];
    assign jdo_addr  = jdo[ADDR_W+ADDR_LSB-1:ADDR_LSB];

    assign any_strobe   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign multi_strobe = (take_action_ocimem_a & take_no_action_ocimem_a) |
                          (take_action_ocimem_a & take_action_ocimem_b) |
                          (take_no_action_ocimem_a & take_action_ocimem_b);

    // Only counts while a request is actually on the bus.
    assign tmo_inc = (rd_q | wr_q) & oci_waitrequest;

    ads131a0x_nios_cpu_debug_ocimem_tmo #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr_i     (tmo_clr),
        .inc_i     (tmo_inc),
        .expired_o (tmo_exp)
    );

    always_comb begin
        state_d = state_q;
        maddr_d = maddr_q;
        mdata_d = mdata_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdy_d   = rdy_q;
        err_d   = err_q;
        tmo_clr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (take_action_ocimem_b) begin
                    wdata_d = jdo_wdata;
                    mdata_d = jdo_wdata;
                    wr_d    = 1'b1;
                    rdy_d   = 1'b0;
                    tmo_clr = 1'b1;
                    state_d = ST_WR;
                end else if (take_action_ocimem_a) begin
                    maddr_d = jdo_addr;
                    if (jdo[RD_BIT]) begin
                        rd_d    = 1'b1;
                        rdy_d   = 1'b0;
                        tmo_clr = 1'b1;
                        state_d = ST_RD;
                    end
                end else if (take_no_action_ocimem_a) begin
                    maddr_d = maddr_q + ADDR_W'(1);
                    rd_d    = 1'b1;
                    rdy_d   = 1'b0;
                    tmo_clr = 1'b1;
                    state_d = ST_RD;
                end
                if (multi_strobe)
                    err_d = 1'b1;
                // The clear only applies when ocimem_a is the command that runs,
                // and it overrides the drop error raised in the same cycle.
                if (take_action_ocimem_a && !take_action_ocimem_b && jdo[CLR_ERR_BIT])
                    err_d = 1'b0;
            end

            ST_RD: begin
                if (any_strobe)
                    err_d = 1'b1;
                if (!oci_waitrequest) begin
                    mdata_d = oci_readdata;
                    rd_d    = 1'b0;
                    rdy_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmo_exp) begin
                    rd_d    = 1'b0;
                    rdy_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_WR: begin
                if (any_strobe)
                    err_d = 1'b1;
                if (!oci_waitrequest) begin
                    wr_d    = 1'b0;
                    maddr_d = maddr_q + ADDR_W'(1);
                    rdy_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmo_exp) begin
                    wr_d    = 1'b0;
                    rdy_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                rdy_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            maddr_q <= '0;
            mdata_q <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdy_q   <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            maddr_q <= maddr_d;
            mdata_q <= mdata_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
        end
    end

    // MonAReg only moves at launch (same edge the request rises) or at
    // completion (same edge it falls), so the bus address is stable for the
    // whole request without a separate register.
    assign oci_address   = maddr_q;
    assign oci_read      = rd_q;
    assign oci_write     = wr_q;
    assign oci_writedata = wdata_q;
    assign MonAReg       = maddr_q;
    assign MonDReg       = mdata_q;
    assign monitor_ready = rdy_q;
    assign monitor_error = err_q;

endmodule

// File: tb/tb_ads131a0x_nios_cpu_debug_ocimem_seq.sv
module tb_ads131a0x_nios_cpu_debug_ocimem_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        a, na, b;
    logic [7:0]  oci_address;
    logic        oci_read, oci_write;
    logic [31:0] oci_writedata, oci_readdata;
    logic        oci_waitrequest;
    logic [7:0]  MonAReg;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    int n_chk  = 0;
    int n_fail = 0;

    ads131a0x_nios_cpu_debug_ocimem_seq #(
        .ADDR_W      (8),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (a),
        .take_no_action_ocimem_a (na),
        .take_action_ocimem_b    (b),
        .oci_address             (oci_address),
        .oci_read                (oci_read),
        .oci_write               (oci_write),
        .oci_writedata           (oci_writedata),
        .oci_readdata            (oci_readdata),
        .oci_waitrequest         (oci_waitrequest),
        .MonAReg                 (MonAReg),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] jdo_a(input bit rd, input bit clr, input logic [7:0] addr);
        logic [37:0] j;
        j       = '0;
        j[35]   = rd;
        j[36]   = clr;
        j[9:2]  = addr;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] j;
        j       = '0;
        j[34:3] = d;
        return j;
    endfunction

    initial begin
        reset_n = 1'b0; jdo = '0; a = 0; na = 0; b = 0;
        oci_readdata = '0; oci_waitrequest = 1'b0;
        tick(); tick();
        chk("rst_read",  oci_read, 0);
        chk("rst_write", oci_write, 0);
        chk("rst_addr",  oci_address, 0);
        chk("rst_wdata", oci_writedata, 0);
        chk("rst_mona",  MonAReg, 0);
        chk("rst_mond",  MonDReg, 0);
        chk("rst_rdy",   monitor_ready, 1);
        chk("rst_err",   monitor_error, 0);
        reset_n = 1'b1;
        tick();

        // Load + read at 0x12, zero wait states
        jdo = jdo_a(1, 0, 8'h12); a = 1; oci_readdata = 32'hDEADBEEF;
        tick(); a = 0;
        chk("lr_read",  oci_read, 1);
        chk("lr_addr",  oci_address, 8'h12);
        chk("lr_rdy0",  monitor_ready, 0);
        chk("lr_mona",  MonAReg, 8'h12);
        tick();
        chk("lr_read0", oci_read, 0);
        chk("lr_mond",  MonDReg, 32'hDEADBEEF);
        chk("lr_rdy1",  monitor_ready, 1);

        // Load-only to 0xFF, then write with 3 wait states, address wraps
        jdo = jdo_a(0, 0, 8'hFF); a = 1;
        tick(); a = 0;
        chk("ld_mona", MonAReg, 8'hFF);
        chk("ld_read", oci_read, 0);
        chk("ld_rdy",  monitor_ready, 1);
        jdo = jdo_b(32'h0000A5A5); b = 1; oci_waitrequest = 1;
        tick(); b = 0;
        chk("wr_c1",    oci_write, 1);
        chk("wr_wdata", oci_writedata, 32'h0000A5A5);
        chk("wr_addr",  oci_address, 8'hFF);
        chk("wr_mond",  MonDReg, 32'h0000A5A5);
        chk("wr_rdy0",  monitor_ready, 0);
        tick(); chk("wr_c2", oci_write, 1);
        tick(); chk("wr_c3", oci_write, 1);
        tick(); chk("wr_c4", oci_write, 1);
        oci_waitrequest = 0;
        tick();
        chk("wr_done", oci_write, 0);
        chk("wr_wrap", MonAReg, 8'h00);
        chk("wr_rdy1", monitor_ready, 1);
        chk("wr_err",  monitor_error, 0);

        // Streaming reads from 0x10
        jdo = jdo_a(0, 0, 8'h10); a = 1;
        tick(); a = 0;
        for (int i = 1; i <= 4; i++) begin
            na = 1; oci_readdata = 32'h1000_0000 + 32'(i);
            tick(); na = 0;
            chk("st_read", oci_read, 1);
            chk("st_addr", oci_address, 8'h10 + 8'(i));
            tick();
            chk("st_mond", MonDReg, 32'h1000_0000 + 32'(i));
            chk("st_rdy",  monitor_ready, 1);
        end

        // Timeout: stuck waitrequest, read drops after 4 stall cycles
        jdo = jdo_a(1, 0, 8'h20); a = 1; oci_waitrequest = 1;
        tick(); a = 0;
        for (int i = 0; i < 4; i++) begin
            chk("to_hold", oci_read, 1);
            if (i < 3) tick();
        end
        tick();
        chk("to_drop", oci_read, 0);
        chk("to_err",  monitor_error, 1);
        chk("to_rdy",  monitor_ready, 1);
        chk("to_mond", MonDReg, 32'h1000_0004);
        chk("to_mona", MonAReg, 8'h20);
        oci_waitrequest = 0;
        jdo = jdo_a(0, 1, 8'h30); a = 1;
        tick(); a = 0;
        chk("clr_err",  monitor_error, 0);
        chk("clr_mona", MonAReg, 8'h30);

        // Two strobes together: ocimem_a wins, error raised
        jdo = jdo_a(0, 0, 8'h50); a = 1; na = 1;
        tick(); a = 0; na = 0;
        chk("ms_mona", MonAReg, 8'h50);
        chk("ms_err",  monitor_error, 1);
        chk("ms_read", oci_read, 0);
        // Clear beats a same-cycle drop error
        jdo = jdo_a(0, 1, 8'h60); a = 1; na = 1;
        tick(); a = 0; na = 0;
        chk("mc_err",  monitor_error, 0);
        chk("mc_mona", MonAReg, 8'h60);

        // Busy collision: ocimem_b during a stalled read
        jdo = jdo_a(1, 0, 8'h40); a = 1; oci_waitrequest = 1; oci_readdata = 32'hCAFEF00D;
        tick(); a = 0;
        jdo = jdo_b(32'h00001234); b = 1;
        tick(); b = 0;
        chk("bc_err",   monitor_error, 1);
        chk("bc_read",  oci_read, 1);
        chk("bc_write", oci_write, 0);
        chk("bc_wdata", oci_writedata, 32'h0000A5A5);
        oci_waitrequest = 0;
        tick();
        chk("bc_mond", MonDReg, 32'hCAFEF00D);
        chk("bc_rdy",  monitor_ready, 1);
        chk("bc_mona", MonAReg, 8'h40);
        chk("bc_err2", monitor_error, 1);

        // Reset in the middle of a stalled write
        jdo = jdo_b(32'h00000077); b = 1; oci_waitrequest = 1;
        tick(); b = 0;
        chk("rw_write", oci_write, 1);
        #2 reset_n = 0;
        #1;
        chk("rw_write0", oci_write, 0);
        chk("rw_wdata",  oci_writedata, 0);
        chk("rw_mona",   MonAReg, 0);
        chk("rw_mond",   MonDReg, 0);
        chk("rw_rdy",    monitor_ready, 1);
        chk("rw_err",    monitor_error, 0);
        tick();
        reset_n = 1; oci_waitrequest = 0;
        tick();
        chk("rw_idle", oci_write, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
